bcd_press_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 63 ++++++
 rtl/debounce_filter.sv | 72 +++++++
 rtl/bcd_press_counter.sv | 101 ++++++++++
 tb/tb_bcd_press_counter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit types and two-digit increment/decrement helpers for the seven-segment path.
// Pure combinational functions and constants; no state, no backpressure.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef struct packed {
    logic       wrap;
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  function automatic bcd2_t bcd_inc2(input bcd_digit_t tens, input bcd_digit_t ones);
    bcd2_t r;
    r.wrap = 1'b0;
    r.tens = tens;
    r.ones = ones;
    if (ones < BCD_MAX) begin
      r.ones = ones + bcd_digit_t'(1);
    end else begin
      r.ones = '0;
      if (tens < BCD_MAX) begin
        r.tens = tens + bcd_digit_t'(1);
      end else begin
        r.tens = '0;
        r.wrap = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic bcd2_t bcd_dec2(input bcd_digit_t tens, input bcd_digit_t ones);
    bcd2_t r;
    r.wrap = 1'b0;
    r.tens = tens;
    r.ones = ones;
    if (ones != '0) begin
      r.ones = ones - bcd_digit_t'(1);
    end else begin
      r.ones = BCD_MAX;
      if (tens != '0) begin
        r.tens = tens - bcd_digit_t'(1);
      end else begin
        r.tens = BCD_MAX;
        r.wrap = 1'b1;
      end
    end
    return r;
  endfunction

  // Binary 0..99 to packed BCD, used for elaboration-time reset constants.
  function automatic bcd2_t bcd_from_int(input int v);
    bcd2_t r;
    r.wrap = 1'b0;
    r.tens = bcd_digit_t'((v / 10) % 10);
    r.ones = bcd_digit_t'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser + counter debounce + registered rising-edge pulse for one push-button.
// Latency: raw edge to o_Rise = 2 + DEBOUNCE_LIMIT + 1 cycles; no backpressure.
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Stable,
  output logic o_Rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } deb_state_t;

  logic [1:0]       sync_q;
  logic             sw_sync;
  deb_state_t       sw_stable;
  deb_state_t       stable_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_hi;
  logic             stable_prev;
  logic             rise_q;

  assign sw_sync   = sync_q[1];
  assign stable_hi = (sw_stable == STABLE_HI);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], i_Raw};
    end
  end

  // Any cycle where the synchronised input agrees with the accepted level restarts the count.
  always_comb begin
    stable_nxt = sw_stable;
    cnt_nxt    = '0;
    if (sw_sync != stable_hi) begin
      if (cnt_q == CNT_LAST) begin
        stable_nxt = stable_hi ? STABLE_LO : STABLE_HI;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sw_stable   <= STABLE_LO;
      cnt_q       <= '0;
      stable_prev <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sw_stable   <= stable_nxt;
      cnt_q       <= cnt_nxt;
      stable_prev <= stable_hi;
      rise_q      <= stable_hi & ~stable_prev;
    end
  end

  assign o_Stable = stable_hi;
  assign o_Rise   = rise_q;

endmodule

// File: rtl/bcd_press_counter.sv
// Counts debounced i_Switch_1 presses as BCD 00..99 (wrapping); COUNT_DOWN_EN adds i_Switch_2 to count down.
// Latency: clean press edge to o_Update = DEBOUNCE_LIMIT + 4 cycles (+-1 sampling phase); no backpressure.
module bcd_press_counter
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int START_VALUE    = 0
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Switch_1,
`ifdef COUNT_DOWN_EN
  input  logic             i_Switch_2,
`endif
  output logic [BCD_W-1:0] o_Ones,
  output logic [BCD_W-1:0] o_Tens,
  output logic             o_Update,
  output logic             o_Wrap
);

  localparam bcd2_t START_BCD = bcd_from_int(START_VALUE);

  logic       up_stable;
  logic       up_rise;
  logic       up_ev;
  bcd_digit_t ones_q;
  bcd_digit_t tens_q;
  logic       upd_q;
  logic       wrap_q;
  bcd2_t      nxt;
  logic       upd_nxt;

  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_up (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Raw    (i_Switch_1),
    .o_Stable (up_stable),
    .o_Rise   (up_rise)
  );

  // The rise pulse is only honoured while the debounced level is still held.
  assign up_ev = up_rise & up_stable;

`ifdef COUNT_DOWN_EN
  logic dn_stable;
  logic dn_rise;
  logic dn_ev;

  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_dn (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Raw    (i_Switch_2),
    .o_Stable (dn_stable),
    .o_Rise   (dn_rise)
  );

  assign dn_ev = dn_rise & dn_stable;
`endif

  always_comb begin
    nxt.wrap = 1'b0;
    nxt.tens = tens_q;
    nxt.ones = ones_q;
    upd_nxt  = 1'b0;
`ifdef COUNT_DOWN_EN
    // Simultaneous up and down events cancel out.
    if (up_ev && !dn_ev) begin
      nxt     = bcd_inc2(tens_q, ones_q);
      upd_nxt = 1'b1;
    end else if (dn_ev && !up_ev) begin
      nxt     = bcd_dec2(tens_q, ones_q);
      upd_nxt = 1'b1;
    end
`else
    if (up_ev) begin
      nxt     = bcd_inc2(tens_q, ones_q);
      upd_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      ones_q <= START_BCD.ones;
      tens_q <= START_BCD.tens;
      upd_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ones_q <= nxt.ones;
      tens_q <= nxt.tens;
      upd_q  <= upd_nxt;
      wrap_q <= nxt.wrap;
    end
  end

  assign o_Ones   = ones_q;
  assign o_Tens   = tens_q;
  assign o_Update = upd_q;
  assign o_Wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_press_counter.sv
// Self-checking bench for bcd_press_counter: directed plan items plus randomized button activity
// checked every cycle against a run-length/latency reference model.
module tb_bcd_press_counter;

  localparam int LIMIT = 4;
  localparam int START = 0;
  localparam int LAT   = 4;  // last qualifying sample edge to visible digit update

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_Switch_1;
  logic       sw2_drv;
  logic [3:0] o_Ones;
  logic [3:0] o_Tens;
  logic       o_Update;
  logic       o_Wrap;

  always #5 i_Clk = ~i_Clk;

  bcd_press_counter #(.DEBOUNCE_LIMIT(LIMIT), .START_VALUE(START)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Switch_1 (i_Switch_1),
`ifdef COUNT_DOWN_EN
    .i_Switch_2 (sw2_drv),
`endif
    .o_Ones     (o_Ones),
    .o_Tens     (o_Tens),
    .o_Update   (o_Update),
    .o_Wrap     (o_Wrap)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a level is accepted after LIMIT consecutive samples opposite to it;
  // an accepted rise shows on the outputs LAT edges later as a +1 (or -1) modulo 100.
  int        cnt;
  bit        stab [2];
  int        run  [2];
  bit [LAT:0] pipe_up, pipe_dn;
  bit        exp_upd, exp_wrap, in_rst;
  int        cyc, upd_cnt, last_upd_cyc, wrap_val;
  bit        wrap_seen;

  task automatic model_reset();
    cnt = START;
    for (int i = 0; i < 2; i++) begin
      stab[i] = 1'b0;
      run[i]  = 0;
    end
    pipe_up  = '0;
    pipe_dn  = '0;
    exp_upd  = 1'b0;
    exp_wrap = 1'b0;
  endtask

  task automatic model_edge(input bit r1, input bit r2);
    bit ev [2];
    bit r  [2];
    bit up, dn;
    exp_upd  = 1'b0;
    exp_wrap = 1'b0;
    if (in_rst) return;
    r[0] = r1;
    r[1] = r2;
    for (int i = 0; i < 2; i++) begin
      ev[i] = 1'b0;
      if (r[i] != stab[i]) begin
        run[i]++;
        if (run[i] == LIMIT) begin
          stab[i] = r[i];
          run[i]  = 0;
          ev[i]   = r[i];
        end
      end else begin
        run[i] = 0;
      end
    end
    pipe_up = {pipe_up[LAT-1:0], ev[0]};
    pipe_dn = {pipe_dn[LAT-1:0], ev[1]};
    up = pipe_up[LAT];
    dn = pipe_dn[LAT];
    if (up && !dn) begin
      exp_upd  = 1'b1;
      exp_wrap = (cnt == 99);
      cnt      = (cnt + 1) % 100;
    end else if (dn && !up) begin
      exp_upd  = 1'b1;
      exp_wrap = (cnt == 0);
      cnt      = (cnt + 99) % 100;
    end
  endtask

  // Called at a falling edge: drive inputs, advance one clock, compare at the next falling edge.
  task automatic step(input bit r1, input bit r2);
    i_Switch_1 = r1;
    sw2_drv    = r2;
    @(posedge i_Clk);
    cyc++;
    model_edge(r1, r2);
    @(negedge i_Clk);
    chk("ones",   o_Ones,   cnt % 10);
    chk("tens",   o_Tens,   cnt / 10);
    chk("update", o_Update, exp_upd);
    chk("wrap",   o_Wrap,   exp_wrap);
    if (o_Update) begin
      upd_cnt++;
      last_upd_cyc = cyc;
      if (o_Wrap) begin
        wrap_seen = 1'b1;
        wrap_val  = o_Tens * 10 + o_Ones;
      end
    end
  endtask

  task automatic press(input bit up);
    repeat (6) step(up, !up);
    repeat (6) step(1'b0, 1'b0);
  endtask

  // Asserts reset between clock edges and checks the outputs respond before any edge.
  task automatic do_reset();
    #2 i_Rst = 1'b1;
    #1;
    chk("async_rst_ones",   o_Ones,   START % 10);
    chk("async_rst_tens",   o_Tens,   START / 10);
    chk("async_rst_update", o_Update, 0);
    in_rst = 1'b1;
    model_reset();
    repeat (3) step(1'b0, 1'b0);
    i_Rst  = 1'b0;
    in_rst = 1'b0;
  endtask

  int u0, p0, lat;
  bit lvl1, lvl2;
  int len1, len2;

  initial begin
    i_Rst      = 1'b1;
    i_Switch_1 = 1'b0;
    sw2_drv    = 1'b0;
    in_rst     = 1'b1;
    cyc = 0; upd_cnt = 0; last_upd_cyc = 0; wrap_seen = 1'b0; wrap_val = -1;
    model_reset();
    repeat (3) @(negedge i_Clk);
    chk("reset_ones",   o_Ones,   START % 10);
    chk("reset_tens",   o_Tens,   START / 10);
    chk("reset_update", o_Update, 0);
    chk("reset_wrap",   o_Wrap,   0);
    i_Rst  = 1'b0;
    in_rst = 1'b0;
    repeat (5) step(1'b0, 1'b0);

    // Clean press held 20 cycles.
    u0 = upd_cnt;
    p0 = cyc;
    repeat (20) step(1'b1, 1'b0);
    lat = last_upd_cyc - p0;
    chk("clean_single_update", upd_cnt - u0, 1);
    chk("clean_latency_8pm1", (lat >= 7 && lat <= 9) ? 1 : 0, 1);
    chk("clean_value", o_Tens * 10 + o_Ones, 1);
    repeat (10) step(1'b0, 1'b0);

    // 3-cycle glitches, then a steady level.
    u0 = upd_cnt;
    repeat (5) begin
      repeat (3) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
    end
    chk("bounce_no_update", upd_cnt - u0, 0);
    repeat (15) step(1'b1, 1'b0);
    chk("bounce_one_update", upd_cnt - u0, 1);
    repeat (10) step(1'b0, 1'b0);

    // Carry and wrap: currently 02.
    repeat (7) press(1'b1);
    chk("carry_09", o_Tens * 10 + o_Ones, 9);
    press(1'b1);
    chk("carry_10", o_Tens * 10 + o_Ones, 10);
    repeat (89) press(1'b1);
    chk("reach_99", o_Tens * 10 + o_Ones, 99);
    wrap_seen = 1'b0;
    press(1'b1);
    chk("wrap_with_update", wrap_seen, 1);
    chk("wrap_to_00", wrap_val, 0);

    // Long hold produces one event.
    u0 = upd_cnt;
    repeat (100) step(1'b1, 1'b0);
    chk("held_single", upd_cnt - u0, 1);
    repeat (8) step(1'b0, 1'b0);

    // Reset in the middle of a second press debounce.
    repeat (2) step(1'b1, 1'b0);
    do_reset();
    u0 = upd_cnt;
    repeat (12) step(1'b0, 1'b0);
    chk("no_spurious_after_rst", upd_cnt - u0, 0);
    chk("rst_value_00", o_Tens * 10 + o_Ones, 0);

    // Randomized run-length activity on the buttons.
    lvl1 = 1'b0; lvl2 = 1'b0; len1 = 0; len2 = 0;
    repeat (800) begin
      if (len1 == 0) begin
        lvl1 = $urandom_range(0, 1);
        len1 = $urandom_range(1, 9);
      end
      if (len2 == 0) begin
        lvl2 = $urandom_range(0, 1);
        len2 = $urandom_range(1, 9);
      end
`ifdef COUNT_DOWN_EN
      step(lvl1, lvl2);
`else
      step(lvl1, 1'b0);
`endif
      len1--;
      len2--;
    end
    repeat (12) step(1'b0, 1'b0);

`ifdef COUNT_DOWN_EN
    do_reset();
    repeat (4) step(1'b0, 1'b0);
    wrap_seen = 1'b0;
    press(1'b0);
    chk("down_wrap_seen", wrap_seen, 1);
    chk("down_wrap_99", wrap_val, 99);
    press(1'b1);
    chk("up_back_00", o_Tens * 10 + o_Ones, 0);
    repeat (10) press(1'b1);
    chk("up_to_10", o_Tens * 10 + o_Ones, 10);
    press(1'b0);
    chk("down_10_to_09", o_Tens * 10 + o_Ones, 9);
    u0 = upd_cnt;
    repeat (6) step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    chk("cancel_no_update", upd_cnt - u0, 0);
    chk("cancel_value", o_Tens * 10 + o_Ones, 9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
